uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmit path among NREQ byte requesters.
// One requester wins, its byte is latched onto txdata_o, and a single-cycle write
// strobe goes to the TxD buffer. The arbiter then follows the TxRDY handshake: first
// TxRDY low (buffer full), then TxRDY high (frame done). After that it re-arbitrates.
// A saturating wait counter aborts either wait state after TIMEOUT cycles.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   req_i          per-requester request, held with data until ack
//   data_i         packed bytes, requester i at [i*DW +: DW]
//   txrdy_i        1 = TxD buffer empty / transmitter idle
//   wr_o           single-cycle write strobe to the TxD buffer
//   txdata_o       latched byte, held until the next grant
//   grant_o        one-hot current owner, zero when idle
//   ack_o          one-cycle pulse to the winner on the write cycle
//   busy_o         high in any state other than idle
//   timeout_err_o  one-cycle pulse when a wait state aborts
module uart_tx_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*DW-1:0] data_i,
  input  logic               txrdy_i,
  output logic               wr_o,
  output logic [DW-1:0]      txdata_o,
  output logic [NREQ-1:0]    grant_o,
  output logic [NREQ-1:0]    ack_o,
  output logic               busy_o,
  output logic               timeout_err_o
);

  localparam int unsigned     IdxW       = $clog2(NREQ);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(NREQ - 1);
  localparam logic [9:0]      TimeoutCnt = 10'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StWrite, StWaitLow, StWaitHigh} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] win_q, win_d;
  logic [DW-1:0]   txdata_q, txdata_d;
  logic [9:0]      cnt_q, cnt_d;

  logic            pick_vld;
  logic [IdxW-1:0] pick_idx;
  logic [DW-1:0]   pick_data;
  logic [IdxW:0]   cand;
  logic [IdxW-1:0] cand_idx;
  logic            timeout;

  // Winner search: first set request starting at ptr+1, wrapping modulo NREQ.
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_data = '0;
    cand      = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IdxW+1)'(i) + (IdxW+1)'(1);
      if (cand >= (IdxW+1)'(NREQ)) begin
        cand = cand - (IdxW+1)'(NREQ);
      end
      cand_idx = cand[IdxW-1:0];
      if (!pick_vld && req_i[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (pick_idx == IdxW'(j)) begin
        pick_data = data_i[j*DW +: DW];
      end
    end
  end

  // Abort only while the awaited TxRDY level is still absent.
  always_comb begin
    timeout = 1'b0;
    if (cnt_q == TimeoutCnt) begin
      if (state_q == StWaitLow) begin
        timeout = txrdy_i;
      end else if (state_q == StWaitHigh) begin
        timeout = ~txrdy_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      ptr_q    <= LastIdx;
      win_q    <= '0;
      txdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      txdata_q <= txdata_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    txdata_d = txdata_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld && txrdy_i) begin
          state_d  = StWrite;
          win_d    = pick_idx;
          txdata_d = pick_data;
        end
      end
      StWrite: begin
        state_d = StWaitLow;
        cnt_d   = '0;
      end
      StWaitLow: begin
        // A TxRDY high here is the pre-write level or a glitch; only low counts.
        if (!txrdy_i) begin
          state_d = StWaitHigh;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = StIdle;
          ptr_d   = win_q;
        end else if (cnt_q != TimeoutCnt) begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      StWaitHigh: begin
        // Pointer advances on timeout too, so a stuck frame cannot starve others.
        if (txrdy_i || timeout) begin
          state_d = StIdle;
          ptr_d   = win_q;
        end else if (cnt_q != TimeoutCnt) begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_o          = (state_q == StWrite);
    busy_o        = (state_q != StIdle);
    grant_o       = '0;
    if (busy_o) begin
      grant_o[win_q] = 1'b1;
    end
    ack_o         = wr_o ? grant_o : '0;
    txdata_o      = txdata_q;
    timeout_err_o = timeout;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic        txrdy;
  logic        wr;
  logic [7:0]  txdata;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        busy;
  logic        terr;

  int n_chk  = 0;
  int n_fail = 0;
  int last;

  uart_tx_arbiter #(
    .NREQ   (NREQ),
    .DW     (DW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .data_i       (data),
    .txrdy_i      (txrdy),
    .wr_o         (wr),
    .txdata_o     (txdata),
    .grant_o      (grant),
    .ack_o        (ack),
    .busy_o       (busy),
    .timeout_err_o(terr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_rst;
    logic [3:0]  req;
    logic [31:0] data;
    int          glitch;
    int          hi;
    int          exp_w;
    logic [7:0]  exp_b;
  } vec_t;

  vec_t tbl[12];

  // Round-robin reference: winner is the requesting index at the smallest
  // circular distance after the last one served.
  function automatic int rr_pick(input logic [3:0] r, input int lst);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = NREQ + 1;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - lst - 1 + 2 * NREQ) % NREQ;
      if (r[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    data  = '0;
    txrdy = 1'b1;
    @(negedge clk);
    chk("rst_wr", {31'd0, wr}, 0);
    chk("rst_ack", {28'd0, ack}, 0);
    chk("rst_grant", {28'd0, grant}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_terr", {31'd0, terr}, 0);
    chk("rst_txdata", {24'd0, txdata}, 0);
    rst  = 1'b0;
    last = NREQ - 1;
  endtask

  task automatic wait_wr(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (wr !== 1'b1 && cyc < 8);
  endtask

  // Entered at the write-strobe cycle; plays the transmitter side to the end.
  task automatic finish_frame(input int w, input logic [7:0] b, input int glitch, input int hi);
    chk("grant", {28'd0, grant}, 32'(1 << w));
    chk("txdata", {24'd0, txdata}, {24'd0, b});
    chk("ack", {28'd0, ack}, 32'(1 << w));
    chk("busy_wr", {31'd0, busy}, 1);
    req  = 4'($urandom);
    data = $urandom;
    @(negedge clk);
    chk("wr_one_cycle", {31'd0, wr}, 0);
    chk("ack_one_cycle", {28'd0, ack}, 0);
    repeat (glitch) begin
      @(negedge clk);
      chk("waitlow_no_wr", {31'd0, wr}, 0);
      chk("waitlow_busy", {31'd0, busy}, 1);
    end
    txrdy = 1'b0;
    repeat (hi) begin
      @(negedge clk);
      chk("waithigh_busy", {31'd0, busy}, 1);
      chk("waithigh_grant", {28'd0, grant}, 32'(1 << w));
      chk("txdata_held", {24'd0, txdata}, {24'd0, b});
    end
    txrdy = 1'b1;
    req   = '0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_grant", {28'd0, grant}, 0);
    chk("idle_terr", {31'd0, terr}, 0);
    chk("idle_txdata", {24'd0, txdata}, {24'd0, b});
    last = w;
  endtask

  task automatic run_frame(input logic [3:0] r, input logic [31:0] d, input int glitch,
                           input int hi, input int w, input logic [7:0] b);
    int cyc;
    req   = r;
    data  = d;
    txrdy = 1'b1;
    wait_wr(cyc);
    chk("wr_latency", cyc, 1);
    finish_frame(w, b, glitch, hi);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int n;
    int w;
    logic [3:0]  r;
    logic [31:0] d;

    tbl[0]  = '{1'b1, 4'b0001, 32'h0000_00A5, 0, 11, 0, 8'hA5};
    tbl[1]  = '{1'b1, 4'b1111, 32'h1312_1110, 0, 3, 0, 8'h10};
    tbl[2]  = '{1'b0, 4'b1111, 32'h1312_1110, 1, 2, 1, 8'h11};
    tbl[3]  = '{1'b0, 4'b1111, 32'h1312_1110, 0, 2, 2, 8'h12};
    tbl[4]  = '{1'b0, 4'b1111, 32'h1312_1110, 0, 2, 3, 8'h13};
    tbl[5]  = '{1'b0, 4'b1111, 32'h1312_1110, 0, 2, 0, 8'h10};
    tbl[6]  = '{1'b0, 4'b0100, 32'h4433_2211, 0, 2, 2, 8'h33};
    tbl[7]  = '{1'b0, 4'b0101, 32'h4433_2211, 2, 3, 0, 8'h11};
    tbl[8]  = '{1'b0, 4'b0101, 32'h4433_2211, 0, 2, 2, 8'h33};
    tbl[9]  = '{1'b0, 4'b1000, 32'hDEAD_BEEF, 3, 4, 3, 8'hDE};
    tbl[10] = '{1'b0, 4'b0010, 32'hDEAD_BEEF, 0, 1, 1, 8'hBE};
    tbl[11] = '{1'b0, 4'b0010, 32'h0000_C300, 1, 1, 1, 8'hC3};

    rst   = 1'b1;
    req   = '0;
    data  = '0;
    txrdy = 1'b1;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].do_rst) do_reset();
      run_frame(tbl[i].req, tbl[i].data, tbl[i].glitch, tbl[i].hi, tbl[i].exp_w, tbl[i].exp_b);
    end

    // TxRDY low in idle holds off arbitration.
    req   = 4'b0010;
    data  = 32'h0000_5A00;
    txrdy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rdy_low_wr", {31'd0, wr}, 0);
      chk("rdy_low_grant", {28'd0, grant}, 0);
      chk("rdy_low_busy", {31'd0, busy}, 0);
    end
    txrdy = 1'b1;
    wait_wr(cyc);
    chk("rdy_release_latency", {31'd0, cyc <= 2}, 1);
    finish_frame(rr_pick(4'b0010, last), 8'h5A, 0, 3);

    // TxRDY stuck low after the write: abort from the wait-for-high state.
    w     = rr_pick(4'b0001, last);
    req   = 4'b0001;
    data  = 32'h0000_0077;
    txrdy = 1'b1;
    wait_wr(cyc);
    chk("to_wr_latency", cyc, 1);
    chk("to_grant", {28'd0, grant}, 32'(1 << w));
    req = '0;
    @(negedge clk);
    txrdy = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (terr !== 1'b1 && n < 1100);
    chk("timeout_cycles", n - 1, TIMEOUT);
    chk("timeout_busy", {31'd0, busy}, 1);
    @(negedge clk);
    chk("timeout_pulse_once", {31'd0, terr}, 0);
    chk("timeout_idle", {31'd0, busy}, 0);
    chk("timeout_grant", {28'd0, grant}, 0);
    last  = w;
    txrdy = 1'b1;
    run_frame(4'b0011, 32'h0000_6655, 0, 2, rr_pick(4'b0011, last), 8'h66);

    // Reset while waiting for the frame to finish.
    w     = rr_pick(4'b0100, last);
    req   = 4'b0100;
    data  = 32'h0099_0000;
    txrdy = 1'b1;
    wait_wr(cyc);
    @(negedge clk);
    txrdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_grant", {28'd0, grant}, 32'b0100);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_grant", {28'd0, grant}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_wr", {31'd0, wr}, 0);
    rst   = 1'b0;
    txrdy = 1'b1;
    last  = NREQ - 1;
    run_frame(4'b1111, 32'h1312_1110, 0, 2, 0, 8'h10);

    // Randomized frames against the reference model.
    for (int k = 0; k < 40; k++) begin
      r = 4'($urandom_range(1, 15));
      d = $urandom;
      w = rr_pick(r, last);
      run_frame(r, d, $urandom_range(0, 2), $urandom_range(1, 6), w, d[w*8 +: 8]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
